chrom_eval_initiator: RTL

//  Initiator side of the chromosome-evaluation handshake (start / ready / done / feedback).

---
 rtl/chrom_eval_pkg.sv | 29 ++
 rtl/chrom_seg_regfile.sv | 40 ++++
 rtl/chrom_eval_initiator.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/chrom_eval_pkg.sv
// Shared types and constants for the chromosome-evaluation initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package chrom_eval_pkg;

  localparam int NUM_SEGS  = 31;
  localparam int SEG_W     = 32;
  localparam int NUM_SUMS  = 8;
  localparam int SUM_W     = 32;
  localparam int ADDR_W    = 5;
  localparam int RUN_CNT_W = 16;
  localparam int CHROM_W   = NUM_SEGS * SEG_W;
  localparam int SUMS_W    = NUM_SUMS * SUM_W;

  // Encoding is visible on oState, so values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_WAIT_DONE  = 3'd2,
    ST_FEEDBACK   = 3'd3,
    ST_RESULT     = 3'd4
  } state_e;

  // States in which a run is in flight and the chromosome must stay frozen.
  function automatic logic is_busy(input state_e s);
    return (s == ST_WAIT_READY) || (s == ST_WAIT_DONE) || (s == ST_FEEDBACK);
  endfunction

endpackage

// File: rtl/chrom_seg_regfile.sv
// Segment register file: N x W flops, one write port, whole contents flattened.
// Latency: write visible on segs_o the cycle after wr_en_i.
// Backpressure: none; caller gates wr_en_i. Addresses >= N are dropped.
//
// Ports:
//   clk_i, rst_ni          clock, async active-low reset (clears all segments)
//   wr_en_i/addr_i/data_i  write port
//   segs_o                 {seg[N-1] .. seg[0]}
module chrom_seg_regfile #(
  parameter int N  = 31,
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  output logic [N*W-1:0] segs_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  logic [W-1:0] seg_q [N];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        seg_q[i] <= '0;
      end
    end else if (wr_en_i && (wr_addr_i <= LAST_ADDR)) begin
      seg_q[wr_addr_i] <= wr_data_i;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign segs_o[g*W +: W] = seg_q[g];
  end

endmodule

// File: rtl/chrom_eval_initiator.sv
// Initiator for the chromosome-evaluation start/ready/done/feedback handshake.
// Latency: iGo with responder ready -> oStartProcessing two cycles later; all outputs registered.
// Backpressure: result held valid until iResultAck or a new iGo; iGo and writes ignored while oBusy.
//
// Optional feature: define CHROM_EVAL_TIMEOUT_EN to enable the run watchdog
// (TIMEOUT_CYCLES cycles across WAIT_DONE/FEEDBACK). Without it oTimeout is 0.
//
// Ports:
//   iClock, iReset_n            clock, async active-low reset
//   iWrEn/iWrAddr/iWrData       chromosome segment write (addr 31 ignored)
//   iGo                         start one evaluation run
//   oBusy                       run in flight
//   oChromDescription           {seg30..seg0} to responder
//   oStartProcessing            start handshake to responder
//   iReadyToProcess             responder ready
//   iDoneProcessing             responder done
//   oDoneProcessingFeedback     done acknowledge to responder
//   iErrorSums / oErrorSums     responder sums / captured sums
//   oResultValid / iResultAck   result handshake to consumer
//   oRunCount                   completed runs (wraps)
//   oTimeout                    last run aborted by watchdog
//   oState                      FSM state, debug
module chrom_eval_initiator
  import chrom_eval_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                 iClock,
  input  logic                 iReset_n,
  input  logic                 iWrEn,
  input  logic [ADDR_W-1:0]    iWrAddr,
  input  logic [SEG_W-1:0]     iWrData,
  input  logic                 iGo,
  output logic                 oBusy,
  output logic [CHROM_W-1:0]   oChromDescription,
  output logic                 oStartProcessing,
  input  logic                 iReadyToProcess,
  input  logic                 iDoneProcessing,
  output logic                 oDoneProcessingFeedback,
  input  logic [SUMS_W-1:0]    iErrorSums,
  output logic [SUMS_W-1:0]    oErrorSums,
  output logic                 oResultValid,
  input  logic                 iResultAck,
  output logic [RUN_CNT_W-1:0] oRunCount,
  output logic                 oTimeout,
  output logic [2:0]           oState
);

  // The watchdog needs at least one counting cycle before it can expire.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout_cfg
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   start_q, start_d;
  logic                   fb_q, fb_d;
  logic                   valid_q, valid_d;
  logic [RUN_CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic [SUMS_W-1:0]      sums_q, sums_d;
  logic                   wr_accept;

  // Chromosome is frozen for the whole run; a write in the same cycle as iGo
  // still lands because state_q is IDLE/RESULT on that edge.
  assign wr_accept = iWrEn && !is_busy(state_q);

  chrom_seg_regfile #(
    .N  (NUM_SEGS),
    .W  (SEG_W),
    .AW (ADDR_W)
  ) u_segs (
    .clk_i     (iClock),
    .rst_ni    (iReset_n),
    .wr_en_i   (wr_accept),
    .wr_addr_i (iWrAddr),
    .wr_data_i (iWrData),
    .segs_o    (oChromDescription)
  );

`ifdef CHROM_EVAL_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            wd_expired;

  assign wd_expired = (wd_q == WD_LAST);

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign oTimeout = timeout_q;
`else
  assign oTimeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    start_d   = start_q;
    fb_d      = fb_q;
    valid_d   = valid_q;
    run_cnt_d = run_cnt_q;
    sums_d    = sums_q;
`ifdef CHROM_EVAL_TIMEOUT_EN
    wd_d      = wd_q;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (iGo) begin
          state_d = ST_WAIT_READY;
          busy_d  = 1'b1;
        end
      end

      ST_WAIT_READY: begin
        if (iReadyToProcess) begin
          state_d = ST_WAIT_DONE;
          start_d = 1'b1;
`ifdef CHROM_EVAL_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end

      ST_WAIT_DONE: begin
`ifdef CHROM_EVAL_TIMEOUT_EN
        wd_d = wd_q + 1'b1;
`endif
        if (iDoneProcessing) begin
          state_d = ST_FEEDBACK;
          sums_d  = iErrorSums;
          start_d = 1'b0;
          fb_d    = 1'b1;
        end
      end

      ST_FEEDBACK: begin
`ifdef CHROM_EVAL_TIMEOUT_EN
        wd_d = wd_q + 1'b1;
`endif
        if (!iDoneProcessing) begin
          state_d   = ST_RESULT;
          fb_d      = 1'b0;
          valid_d   = 1'b1;
          busy_d    = 1'b0;
          run_cnt_d = run_cnt_q + 1'b1;
`ifdef CHROM_EVAL_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end

      ST_RESULT: begin
        // A new run takes priority over a same-cycle acknowledge.
        if (iGo) begin
          state_d = ST_WAIT_READY;
          valid_d = 1'b0;
          busy_d  = 1'b1;
        end else if (iResultAck) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        start_d = 1'b0;
        fb_d    = 1'b0;
        valid_d = 1'b0;
      end
    endcase

`ifdef CHROM_EVAL_TIMEOUT_EN
    // Watchdog abort overrides whatever the handshake would have done this cycle.
    if (((state_q == ST_WAIT_DONE) || (state_q == ST_FEEDBACK)) && wd_expired) begin
      state_d   = ST_RESULT;
      start_d   = 1'b0;
      fb_d      = 1'b0;
      busy_d    = 1'b0;
      valid_d   = 1'b1;
      sums_d    = '1;
      run_cnt_d = run_cnt_q;
      timeout_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      fb_q      <= 1'b0;
      valid_q   <= 1'b0;
      run_cnt_q <= '0;
      sums_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      fb_q      <= fb_d;
      valid_q   <= valid_d;
      run_cnt_q <= run_cnt_d;
      sums_q    <= sums_d;
    end
  end

  assign oBusy                   = busy_q;
  assign oStartProcessing        = start_q;
  assign oDoneProcessingFeedback = fb_q;
  assign oResultValid            = valid_q;
  assign oRunCount               = run_cnt_q;
  assign oErrorSums              = sums_q;
  assign oState                  = state_q;

endmodule
